m_pipe_reg: RTL and testbench

- Execute-to-memory pipeline register. Sits directly upstream of the data memory stage and drives its M_op / M_valE / M_valA inputs.
- Latches execute-stage results each cycle and supports hazard-unit stall and bubble control.
- Detects illegal opcodes and enters a halt state that feeds only bubbles to memory.
- Exports M-stage forwarding info to the hazard/forward unit.

---
 rtl/m_pipe_reg.sv | 139 +++++++++++++
 tb/tb_m_pipe_reg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_pipe_reg.sv
// rtl/m_pipe_reg.sv - execute-to-memory pipeline register with stall/bubble, illegal-opcode halt and forwarding info
// Optional load/store counters are built when PERF_CNT_EN is defined.

`ifndef ILW
`define ILW  6'h23
`endif
`ifndef ISW
`define ISW  6'h2B
`endif
`ifndef IROP
`define IROP 6'h00
`endif
`ifndef IJ
`define IJ   6'h02
`endif

module m_pipe_reg #(
    parameter logic [5:0] NOP_OP = 6'h3F,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       e_op,
    input  logic [31:0]      e_valE,
    input  logic [31:0]      e_valA,
    input  logic [4:0]       e_dstE,
    input  logic             e_valid,
    input  logic             M_stall,
    input  logic             M_bubble,
    output logic [5:0]       M_op,
    output logic [31:0]      M_valE,
    output logic [31:0]      M_valA,
    output logic [4:0]       M_dstE,
    output logic             M_valid,
    output logic             M_fwd_en,
    output logic [4:0]       M_fwd_dst,
    output logic             M_is_load,
    output logic             halted,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);

    typedef enum logic {RUN, HALT} stateT;

    stateT state;
    logic  opLegal;
    logic  takeInput;

    always_comb begin
        opLegal = 1'b0;
        case (e_op)
            `ILW, `ISW, `IROP, `IJ: opLegal = 1'b1;
            default:                opLegal = (e_op == NOP_OP);
        endcase
    end

    // Asserted exactly on edges that capture a real instruction (priority case 5).
    assign takeInput = (state == RUN) && !M_bubble && !M_stall && e_valid && opLegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            halted  <= 1'b0;
            M_op    <= NOP_OP;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= '0;
            M_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (M_bubble) begin
                        M_op    <= NOP_OP;
                        M_dstE  <= '0;
                        M_valid <= 1'b0;
                    end else if (M_stall) begin
                        M_op    <= M_op;
                    end else if (!e_valid) begin
                        M_op    <= NOP_OP;
                        M_dstE  <= '0;
                        M_valid <= 1'b0;
                    end else if (!opLegal) begin
                        M_op    <= NOP_OP;
                        M_dstE  <= '0;
                        M_valid <= 1'b0;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        M_op    <= e_op;
                        M_valE  <= e_valE;
                        M_valA  <= e_valA;
                        M_dstE  <= e_dstE;
                        M_valid <= 1'b1;
                    end
                end
                HALT: begin
                    // Memory sees only bubbles until reset.
                    M_op    <= NOP_OP;
                    M_dstE  <= '0;
                    M_valid <= 1'b0;
                    halted  <= 1'b1;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    assign M_fwd_en  = M_valid && ((M_op == `IROP) || (M_op == `ILW)) && (M_dstE != 5'd0);
    assign M_fwd_dst = M_dstE;
    assign M_is_load = M_valid && (M_op == `ILW);

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] ldCount;
    logic [CNT_W-1:0] stCount;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ldCount <= '0;
            stCount <= '0;
        end else if (takeInput) begin
            if ((e_op == `ILW) && (ldCount != {CNT_W{1'b1}}))
                ldCount <= ldCount + 1'b1;
            if ((e_op == `ISW) && (stCount != {CNT_W{1'b1}}))
                stCount <= stCount + 1'b1;
        end
    end

    assign ld_cnt = ldCount;
    assign st_cnt = stCount;
`else
    logic unusedTake;
    assign unusedTake = takeInput;
    assign ld_cnt = '0;
    assign st_cnt = '0;
`endif

endmodule

// File: tb/tb_m_pipe_reg.sv
// tb/tb_m_pipe_reg.sv - directed self-checking bench for m_pipe_reg

`ifndef ILW
`define ILW  6'h23
`endif
`ifndef ISW
`define ISW  6'h2B
`endif
`ifndef IROP
`define IROP 6'h00
`endif
`ifndef IJ
`define IJ   6'h02
`endif

module tb_m_pipe_reg;

    localparam logic [5:0] NOP = 6'h3F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  e_op;
    logic [31:0] e_valE;
    logic [31:0] e_valA;
    logic [4:0]  e_dstE;
    logic        e_valid;
    logic        M_stall;
    logic        M_bubble;
    logic [5:0]  M_op;
    logic [31:0] M_valE;
    logic [31:0] M_valA;
    logic [4:0]  M_dstE;
    logic        M_valid;
    logic        M_fwd_en;
    logic [4:0]  M_fwd_dst;
    logic        M_is_load;
    logic        halted;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    m_pipe_reg #(.NOP_OP(6'h3F), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .e_op(e_op), .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_valid(e_valid),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .M_op(M_op), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_valid(M_valid),
        .M_fwd_en(M_fwd_en), .M_fwd_dst(M_fwd_dst), .M_is_load(M_is_load),
        .halted(halted), .ld_cnt(ld_cnt), .st_cnt(st_cnt)
    );

`ifdef PERF_CNT_EN
    logic [5:0]  s_op;
    logic [31:0] s_valE;
    logic [31:0] s_valA;
    logic [4:0]  s_dstE;
    logic        s_valid;
    logic        s_fwd_en;
    logic [4:0]  s_fwd_dst;
    logic        s_is_load;
    logic        s_halted;
    logic [1:0]  s_ld_cnt;
    logic [1:0]  s_st_cnt;

    m_pipe_reg #(.NOP_OP(6'h3F), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .e_op(e_op), .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_valid(e_valid),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .M_op(s_op), .M_valE(s_valE), .M_valA(s_valA), .M_dstE(s_dstE), .M_valid(s_valid),
        .M_fwd_en(s_fwd_en), .M_fwd_dst(s_fwd_dst), .M_is_load(s_is_load),
        .halted(s_halted), .ld_cnt(s_ld_cnt), .st_cnt(s_st_cnt)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] ve, input logic [31:0] va,
                         input logic [4:0] dst, input logic v);
        e_op = op; e_valE = ve; e_valA = va; e_dstE = dst; e_valid = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
        drive(`ISW, 32'h1234, 32'h5678, 5'd3, 1'b1);
        step(); step();
        vectors++;
        if (M_op !== NOP || M_valid !== 1'b0 || M_valE !== 32'd0 || M_valA !== 32'd0 ||
            M_dstE !== 5'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset: op=%h valid=%b valE=%h valA=%h dst=%0d halted=%b, want 3f 0 0 0 0 0",
                     M_op, M_valid, M_valE, M_valA, M_dstE, halted);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        drive(`ISW, 32'd1, 32'd1, 5'd0, 1'b1);
        step();
        vectors++;
        if (M_op !== `ISW || M_valE !== 32'd1 || M_valA !== 32'd1 || M_valid !== 1'b1 ||
            M_is_load !== 1'b0 || M_fwd_en !== 1'b0) begin
            errors++;
            $display("FAIL pass_store: op=%h valE=%h valA=%h valid=%b ld=%b fwd=%b, want 2b 1 1 1 0 0",
                     M_op, M_valE, M_valA, M_valid, M_is_load, M_fwd_en);
        end
        drive(`ILW, 32'd2, 32'd0, 5'd5, 1'b1);
        step();
        vectors++;
        if (M_op !== `ILW || M_valE !== 32'd2 || M_dstE !== 5'd5 || M_is_load !== 1'b1 ||
            M_fwd_en !== 1'b1 || M_fwd_dst !== 5'd5) begin
            errors++;
            $display("FAIL pass_load: op=%h valE=%h dst=%0d ld=%b fwd=%b fdst=%0d, want 23 2 5 1 1 5",
                     M_op, M_valE, M_dstE, M_is_load, M_fwd_en, M_fwd_dst);
        end
    endtask

    task automatic test_stall_bubble();
        drive(`IROP, 32'd3, 32'd9, 5'd7, 1'b1);
        step();
        M_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(`ILW, 32'd100 + i, 32'd50, 5'd9, 1'b1);
            step();
            vectors++;
            if (M_op !== `IROP || M_valE !== 32'd3 || M_dstE !== 5'd7 || M_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: op=%h valE=%0d dst=%0d valid=%b, want 00 3 7 1",
                         i, M_op, M_valE, M_dstE, M_valid);
            end
        end
        M_stall = 1'b0;
        drive(`ILW, 32'd99, 32'd50, 5'd9, 1'b1);
        step();
        vectors++;
        if (M_op !== `ILW || M_valE !== 32'd99 || M_dstE !== 5'd9) begin
            errors++;
            $display("FAIL stall_release: op=%h valE=%0d dst=%0d, want 23 99 9", M_op, M_valE, M_dstE);
        end
        M_stall = 1'b1; M_bubble = 1'b1;
        drive(`IROP, 32'd7, 32'd7, 5'd4, 1'b1);
        step();
        vectors++;
        if (M_op !== NOP || M_valid !== 1'b0 || M_fwd_en !== 1'b0 || M_dstE !== 5'd0 ||
            M_valE !== 32'd99) begin
            errors++;
            $display("FAIL bubble_over_stall: op=%h valid=%b fwd=%b dst=%0d valE=%0d, want 3f 0 0 0 99",
                     M_op, M_valid, M_fwd_en, M_dstE, M_valE);
        end
        M_stall = 1'b0; M_bubble = 1'b0;
        drive(`IROP, 32'd8, 32'd8, 5'd6, 1'b0);
        step();
        vectors++;
        if (M_op !== NOP || M_valid !== 1'b0 || M_valE !== 32'd99) begin
            errors++;
            $display("FAIL invalid_slot: op=%h valid=%b valE=%0d, want 3f 0 99", M_op, M_valid, M_valE);
        end
    endtask

    task automatic test_forward_gating();
        drive(`IROP, 32'd11, 32'd0, 5'd0, 1'b1);
        step();
        vectors++;
        if (M_fwd_en !== 1'b0 || M_valid !== 1'b1) begin
            errors++;
            $display("FAIL fwd_rop_r0: fwd=%b valid=%b, want 0 1", M_fwd_en, M_valid);
        end
        drive(`IJ, 32'd12, 32'd0, 5'd31, 1'b1);
        step();
        vectors++;
        if (M_fwd_en !== 1'b0 || M_valid !== 1'b1 || M_fwd_dst !== 5'd31 || M_op !== `IJ) begin
            errors++;
            $display("FAIL fwd_jump: fwd=%b valid=%b fdst=%0d op=%h, want 0 1 31 02",
                     M_fwd_en, M_valid, M_fwd_dst, M_op);
        end
        drive(`ILW, 32'd13, 32'd0, 5'd0, 1'b1);
        step();
        vectors++;
        if (M_fwd_en !== 1'b0 || M_is_load !== 1'b1) begin
            errors++;
            $display("FAIL fwd_load_r0: fwd=%b ld=%b, want 0 1", M_fwd_en, M_is_load);
        end
        drive(`IROP, 32'd14, 32'd0, 5'd12, 1'b1);
        step();
        vectors++;
        if (M_fwd_en !== 1'b1 || M_fwd_dst !== 5'd12 || M_is_load !== 1'b0) begin
            errors++;
            $display("FAIL fwd_rop: fwd=%b fdst=%0d ld=%b, want 1 12 0", M_fwd_en, M_fwd_dst, M_is_load);
        end
    endtask

    task automatic test_counters();
        do_reset();
        drive(`ILW, 32'd1, 32'd0, 5'd1, 1'b1);
        step();
        M_stall = 1'b1;
        step(); step();
        M_stall = 1'b0;
        step();
        step();
        drive(`ISW, 32'd2, 32'd2, 5'd0, 1'b1);
        step(); step();
        drive(`ISW, 32'd2, 32'd2, 5'd0, 1'b0);
        step();
`ifdef PERF_CNT_EN
        vectors++;
        if (ld_cnt !== 16'd3 || st_cnt !== 16'd2) begin
            errors++;
            $display("FAIL counters: ld=%0d st=%0d, want 3 2", ld_cnt, st_cnt);
        end
        drive(`ILW, 32'd3, 32'd0, 5'd1, 1'b1);
        step(); step();
        vectors++;
        if (s_ld_cnt !== 2'd3 || ld_cnt !== 16'd5) begin
            errors++;
            $display("FAIL counter_saturate: narrow ld=%0d wide ld=%0d, want 3 5", s_ld_cnt, ld_cnt);
        end
`else
        vectors++;
        if (ld_cnt !== 16'd0 || st_cnt !== 16'd0) begin
            errors++;
            $display("FAIL counters_tied: ld=%0d st=%0d, want 0 0", ld_cnt, st_cnt);
        end
`endif
    endtask

    task automatic test_illegal_halt();
        drive(6'h2A, 32'd5, 32'd5, 5'd3, 1'b1);
        step();
        vectors++;
        if (halted !== 1'b1 || M_op !== NOP || M_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_enter: halted=%b op=%h valid=%b, want 1 3f 0", halted, M_op, M_valid);
        end
        drive(`ILW, 32'd6, 32'd6, 5'd4, 1'b1);
        step();
        drive(`ISW, 32'd6, 32'd6, 5'd4, 1'b1);
        step();
        vectors++;
        if (halted !== 1'b1 || M_op !== NOP || M_valid !== 1'b0 || M_fwd_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_sticky: halted=%b op=%h valid=%b fwd=%b, want 1 3f 0 0",
                     halted, M_op, M_valid, M_fwd_en);
        end
`ifdef PERF_CNT_EN
        vectors++;
        if (ld_cnt !== 16'd5 || st_cnt !== 16'd2) begin
            errors++;
            $display("FAIL halt_freeze: ld=%0d st=%0d, want 5 2", ld_cnt, st_cnt);
        end
`endif
        rst_n = 1'b0;
        step();
        vectors++;
        if (halted !== 1'b0 || M_op !== NOP || M_valE !== 32'd0 || M_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b op=%h valE=%0d valid=%b, want 0 3f 0 0",
                     halted, M_op, M_valE, M_valid);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (M_op !== `ISW || M_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_after_reset: op=%h valid=%b, want 2b 1", M_op, M_valid);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall_bubble();
        test_forward_gating();
        test_counters();
        test_illegal_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
